// File: rtl/dm_copy_engine.sv
// Word-by-word DM block copy engine; second DM master beside the CPU datapath.
// Optional DM_COPY_FILL_EN adds a fill mode that writes a constant word without reading.
module dm_copy_engine #(
   parameter int ADDR_BITS = 7,
   parameter int LEN_W     = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len_words,
`ifdef DM_COPY_FILL_EN
   input  logic             fill,
   input  logic [31:0]      fill_data,
`endif
   output logic             busy,
   output logic             done,
   output logic [31:0]      Mem_addr,
   output logic [31:0]      Mem_w_data,
   output logic             Mem_w,
   output logic             Mem_r,
   input  logic [31:0]      Mem_r_data
);

   // state  | meaning
   // S_IDLE | waiting for start; DM port released
   // S_RD   | reading source word into the buffer
   // S_WR   | writing buffer to destination, advancing pointers
   // S_DONE | one-cycle completion pulse
   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

   localparam int PW = ADDR_BITS - 2;

   state_t           state_q, state_d;
   logic [PW-1:0]    src_q, src_d;
   logic [PW-1:0]    dst_q, dst_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [31:0]      buf_q, buf_d;
   logic             fill_q, fill_d;
   logic             fill_in;
   logic [31:0]      fill_data_in;

`ifdef DM_COPY_FILL_EN
   assign fill_in      = fill;
   assign fill_data_in = fill_data;
`else
   assign fill_in      = 1'b0;
   assign fill_data_in = 32'h0;
`endif

   // Pointer bits outside the DM word range are intentionally dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, src_addr[31:ADDR_BITS], src_addr[1:0],
                               dst_addr[31:ADDR_BITS], dst_addr[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
         fill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      fill_d  = fill_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d  = src_addr[ADDR_BITS-1:2];
               dst_d  = dst_addr[ADDR_BITS-1:2];
               cnt_d  = len_words;
               fill_d = fill_in;
               // Fill mode preloads the buffer so WR needs no special data path.
               if (fill_in) buf_d = fill_data_in;
               if (len_words == '0)
                  state_d = S_DONE;
               else if (fill_in)
                  state_d = S_WR;
               else
                  state_d = S_RD;
            end
         end
         S_RD: begin
            buf_d   = Mem_r_data;
            state_d = S_WR;
         end
         S_WR: begin
            src_d = src_q + PW'(1);
            dst_d = dst_q + PW'(1);
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1))
               state_d = S_DONE;
            else if (fill_q)
               state_d = S_WR;
            else
               state_d = S_RD;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      Mem_r      = 1'b0;
      Mem_w      = 1'b0;
      Mem_addr   = 32'h0;
      Mem_w_data = 32'h0;
      case (state_q)
         S_RD: begin
            busy     = 1'b1;
            Mem_r    = 1'b1;
            Mem_addr = {{(32-ADDR_BITS){1'b0}}, src_q, 2'b00};
         end
         S_WR: begin
            busy       = 1'b1;
            Mem_w      = 1'b1;
            Mem_addr   = {{(32-ADDR_BITS){1'b0}}, dst_q, 2'b00};
            Mem_w_data = buf_q;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dm_copy_engine.sv
// Bench for dm_copy_engine: 32-word DM model, vector table, corner sequences, random copies.
`timescale 1ns/1ps
module tb_dm_copy_engine;
   localparam int LEN_W = 6;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic [31:0]      src_addr = '0;
   logic [31:0]      dst_addr = '0;
   logic [LEN_W-1:0] len_words = '0;
`ifdef DM_COPY_FILL_EN
   logic             fill = 1'b0;
   logic [31:0]      fill_data = '0;
`endif
   logic             busy, done, Mem_w, Mem_r;
   logic [31:0]      Mem_addr, Mem_w_data, Mem_r_data;

   logic [31:0] dm [32];
   logic [31:0] dm_init [32];
   logic [31:0] mdl [32];
   logic        preload = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          len;
      int          exp_done;
      int          exp_busy;
   } vec_t;
   vec_t tbl [5];

   always #5 clk = ~clk;

   dm_copy_engine #(.ADDR_BITS(7), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len_words  (len_words),
`ifdef DM_COPY_FILL_EN
      .fill       (fill),
      .fill_data  (fill_data),
`endif
      .busy       (busy),
      .done       (done),
      .Mem_addr   (Mem_addr),
      .Mem_w_data (Mem_w_data),
      .Mem_w      (Mem_w),
      .Mem_r      (Mem_r),
      .Mem_r_data (Mem_r_data)
   );

   assign Mem_r_data = dm[Mem_addr[6:2]];

   always @(negedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) dm[i] <= dm_init[i];
      end else if (Mem_w) begin
         dm[Mem_addr[6:2]] <= Mem_w_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic load_mem();
      for (int i = 0; i < 32; i++) dm_init[i] = mdl[i];
      preload = 1'b1;
      @(negedge clk);
      #1;
      preload = 1'b0;
   endtask

   // Forward word-by-word copy semantics, so overlapping regions replicate data.
   function automatic void model_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                                      input bit f, input logic [31:0] fd);
      int sw = int'(s[6:2]);
      int dw = int'(d[6:2]);
      for (int i = 0; i < n; i++) mdl[(dw + i) % 32] = f ? fd : mdl[(sw + i) % 32];
   endfunction

   task automatic check_mem(input string tag);
      for (int i = 0; i < 32; i++) check($sformatf("%s.dm[%0d]", tag, i), dm[i], mdl[i]);
   endtask

   task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n, input bit hold,
                           output int done_c, output int busy_c, output int rd_c,
                           output int wr_c, output int proto_err);
      int sw = int'(s[6:2]);
      int dw = int'(d[6:2]);
      done_c = -1; busy_c = 0; rd_c = 0; wr_c = 0; proto_err = 0;
      @(negedge clk);
      src_addr  = s;
      dst_addr  = d;
      len_words = n[LEN_W-1:0];
      start     = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         if (busy) busy_c++;
         if (Mem_r && Mem_w) proto_err++;
         if (Mem_r) begin
            if (Mem_addr !== 32'(((sw + rd_c) % 32) * 4)) proto_err++;
            rd_c++;
         end
         if (Mem_w) begin
            if (Mem_addr !== 32'(((dw + wr_c) % 32) * 4)) proto_err++;
            wr_c++;
         end
         if (!busy && (Mem_r || Mem_w || Mem_addr !== 32'h0)) proto_err++;
         if (done) begin
            done_c = c;
            break;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (busy || done) proto_err++;
      end
   endtask

   task automatic check_run(input string tag, input int exp_done, input int exp_busy,
                            input int exp_rd, input int exp_wr,
                            input int dc, input int bc, input int rc, input int wc, input int pe);
      check({tag, ".done_cycle"}, dc, exp_done);
      check({tag, ".busy_cycles"}, bc, exp_busy);
      check({tag, ".reads"}, rc, exp_rd);
      check({tag, ".writes"}, wc, exp_wr);
      check({tag, ".protocol"}, pe, 0);
   endtask

   initial begin
      int dc, bc, rc, wc, pe;
      logic [31:0] s, d, fd;
      int n;
      bit f;

      tbl[0] = '{src: 32'h00,        dst: 32'h40,        len: 4, exp_done: 9,  exp_busy: 8};
      tbl[1] = '{src: 32'h10,        dst: 32'h50,        len: 0, exp_done: 1,  exp_busy: 0};
      tbl[2] = '{src: 32'h78,        dst: 32'h10,        len: 3, exp_done: 7,  exp_busy: 6};
      tbl[3] = '{src: 32'h00,        dst: 32'h04,        len: 5, exp_done: 11, exp_busy: 10};
      tbl[4] = '{src: 32'hFFFF_FF83, dst: 32'h1233_006E, len: 2, exp_done: 5,  exp_busy: 4};

      #1 rst_n = 1'b0;
      #12;
      check("rst.busy", busy, 0);
      check("rst.done", done, 0);
      check("rst.mem_r", Mem_r, 0);
      check("rst.mem_w", Mem_w, 0);
      check("rst.mem_addr", Mem_addr, 0);
      check("rst.mem_w_data", Mem_w_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst.busy", busy, 0);
      check("post_rst.mem_addr", Mem_addr, 0);

      for (int i = 0; i < 32; i++) mdl[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
      mdl[0] = 32'h11223344;
      mdl[1] = 32'h55667788;
      mdl[2] = 32'h99AABBCC;
      mdl[3] = 32'hDDEEFF00;
      load_mem();

      for (int k = 0; k < 5; k++) begin
         run_copy(tbl[k].src, tbl[k].dst, tbl[k].len, 1'b0, dc, bc, rc, wc, pe);
         model_copy(tbl[k].src, tbl[k].dst, tbl[k].len, 1'b0, 32'h0);
         check_run($sformatf("vec%0d", k), tbl[k].exp_done, tbl[k].exp_busy,
                   tbl[k].len, tbl[k].len, dc, bc, rc, wc, pe);
         check_mem($sformatf("vec%0d", k));
         if (k == 0) begin
            check("vec0.dst40", dm[16], 32'h11223344);
            check("vec0.dst44", dm[17], 32'h55667788);
            check("vec0.dst48", dm[18], 32'h99AABBCC);
            check("vec0.dst4C", dm[19], 32'hDDEEFF00);
         end
      end

      // start held high throughout: exactly one transfer, no restart afterwards
      for (int i = 0; i < 32; i++) mdl[i] = $urandom;
      load_mem();
      run_copy(32'h20, 32'h60, 4, 1'b1, dc, bc, rc, wc, pe);
      model_copy(32'h20, 32'h60, 4, 1'b0, 32'h0);
      check_run("hold", 9, 8, 4, 4, dc, bc, rc, wc, pe);
      check_mem("hold");

      // reset in cycle 3 of a 4-word copy
      for (int i = 0; i < 32; i++) mdl[i] = $urandom;
      load_mem();
      @(negedge clk);
      src_addr = 32'h00; dst_addr = 32'h40; len_words = 6'd4; start = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("abort.cycle2_wr", Mem_w, 1);
      @(posedge clk);
      #2;
      check("abort.cycle3_rd", Mem_r, 1);
      rst_n = 1'b0;
      #1;
      check("abort.busy", busy, 0);
      check("abort.mem_w", Mem_w, 0);
      check("abort.mem_r", Mem_r, 0);
      check("abort.mem_addr", Mem_addr, 0);
      check("abort.done", done, 0);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("abort.idle_after", busy, 0);
      mdl[16] = mdl[0];
      check_mem("abort");

`ifdef DM_COPY_FILL_EN
      for (int i = 0; i < 32; i++) mdl[i] = $urandom;
      load_mem();
      fill = 1'b1;
      fill_data = 32'hDEADBEEF;
      run_copy(32'h00, 32'h20, 2, 1'b0, dc, bc, rc, wc, pe);
      fill = 1'b0;
      model_copy(32'h00, 32'h20, 2, 1'b1, 32'hDEADBEEF);
      check_run("fill", 3, 2, 0, 2, dc, bc, rc, wc, pe);
      check("fill.dst20", dm[8], 32'hDEADBEEF);
      check("fill.dst24", dm[9], 32'hDEADBEEF);
      check_mem("fill");
`endif

      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < 32; i++) mdl[i] = $urandom;
         load_mem();
         s  = $urandom;
         d  = $urandom;
         n  = int'($urandom_range(0, 40));
         f  = 1'b0;
         fd = $urandom;
`ifdef DM_COPY_FILL_EN
         f = 1'($urandom_range(0, 1));
         fill = f;
         fill_data = fd;
`endif
         run_copy(s, d, n, 1'b0, dc, bc, rc, wc, pe);
`ifdef DM_COPY_FILL_EN
         fill = 1'b0;
`endif
         model_copy(s, d, n, f, fd);
         check_run($sformatf("rnd%0d", r), f ? n + 1 : 2 * n + 1, f ? n : 2 * n,
                   f ? 0 : n, n, dc, bc, rc, wc, pe);
         check_mem($sformatf("rnd%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
